// File: rtl/clock_adjust_ctrl.sv
// Set-mode controller: debounces three buttons, walks the field selection and issues
// single-cycle up/down requests with auto-repeat and an inactivity timeout back to RUN.
module clock_adjust_ctrl #(
    parameter logic [15:0] DEB_CYCLES    = 16'd50000,
    parameter logic [23:0] REPEAT_DELAY  = 24'd5000000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd1000000,
    parameter logic [5:0]  TIMEOUT_S     = 6'd30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       adjust,
    output logic [5:0] field_sel,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic       blink
);

    typedef enum logic [2:0] {
        StRun,
        StSelSec,
        StSelMin,
        StSelHour,
        StSelDay,
        StSelMonth,
        StSelYear
    } state_e;

    // Button index: 0 = mode, 1 = up, 2 = down.
    logic [2:0]  btn_raw;
    logic [2:0]  sync1_q, sync2_q;
    logic [2:0]  deb_q, deb_d, deb_prev_q;
    logic [15:0] deb_cnt_q [3];
    logic [15:0] deb_cnt_d [3];
    logic [2:0]  press;
    logic        mode_ev;

    state_e      state_q, state_d;
    logic [5:0]  to_cnt_q, to_cnt_d;
    logic [23:0] rep_cnt_q, rep_cnt_d;
    logic        rep_phase_q, rep_phase_d;
    logic        adjust_q, adjust_d;
    logic [5:0]  field_sel_q, field_sel_d;
    logic        up_q, up_d;
    logic        down_q, down_d;
    logic        blink_q, blink_d;

    logic        in_sel;
    logic        entering;
    logic        one_held;
    logic [23:0] rep_limit;

    assign btn_raw = {btn_down, btn_up, btn_mode};
    assign press   = deb_q & ~deb_prev_q;
    assign mode_ev = press[0];

    // Level flips on the sample after the count has reached DEB_CYCLES.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = 16'd0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] >= DEB_CYCLES) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (mode_ev) begin
            unique case (state_q)
                StRun:      state_d = StSelSec;
                StSelSec:   state_d = StSelMin;
                StSelMin:   state_d = StSelHour;
                StSelHour:  state_d = StSelDay;
                StSelDay:   state_d = StSelMonth;
                StSelMonth: state_d = StSelYear;
                default:    state_d = StRun;
            endcase
        end else if ((state_q != StRun) && tick_1hz &&
                     (({1'b0, to_cnt_q} + 7'd1) >= {1'b0, TIMEOUT_S})) begin
            state_d = StRun;
        end
    end

    always_comb begin
        in_sel    = (state_q != StRun);
        entering  = (state_d != StRun) && (state_d != state_q);
        one_held  = deb_q[1] ^ deb_q[2];
        rep_limit = rep_phase_q ? REPEAT_PERIOD : REPEAT_DELAY;

        to_cnt_d = to_cnt_q;
        if ((state_d == StRun) || entering || (|press)) begin
            to_cnt_d = 6'd0;
        end else if (tick_1hz && (to_cnt_q != 6'h3f)) begin
            to_cnt_d = to_cnt_q + 6'd1;
        end

        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        up_d        = 1'b0;
        down_d      = 1'b0;
        // rep_cnt_q == 0 means no repeat run is armed.
        if (!in_sel || mode_ev || (state_d != state_q) || !one_held) begin
            rep_cnt_d   = 24'd0;
            rep_phase_d = 1'b0;
        end else if (press[1] || press[2]) begin
            rep_cnt_d   = 24'd1;
            rep_phase_d = 1'b0;
            up_d        = press[1];
            down_d      = press[2];
        end else if (rep_cnt_q != 24'd0) begin
            if (rep_cnt_q >= rep_limit) begin
                rep_cnt_d   = 24'd1;
                rep_phase_d = 1'b1;
                up_d        = deb_q[1];
                down_d      = deb_q[2];
            end else if (rep_cnt_q != 24'hffffff) begin
                rep_cnt_d = rep_cnt_q + 24'd1;
            end
        end

        blink_d = blink_q;
        if ((state_d == StRun) || entering) begin
            blink_d = 1'b1;
        end else if (tick_1hz) begin
            blink_d = ~blink_q;
        end

        adjust_d = (state_d != StRun);
        unique case (state_d)
            StSelSec:   field_sel_d = 6'b000001;
            StSelMin:   field_sel_d = 6'b000010;
            StSelHour:  field_sel_d = 6'b000100;
            StSelDay:   field_sel_d = 6'b001000;
            StSelMonth: field_sel_d = 6'b010000;
            StSelYear:  field_sel_d = 6'b100000;
            default:    field_sel_d = 6'b000000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 3'b000;
            sync2_q     <= 3'b000;
            deb_q       <= 3'b000;
            deb_prev_q  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= 16'd0;
            end
            state_q     <= StRun;
            to_cnt_q    <= 6'd0;
            rep_cnt_q   <= 24'd0;
            rep_phase_q <= 1'b0;
            adjust_q    <= 1'b0;
            field_sel_q <= 6'b000000;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            blink_q     <= 1'b1;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_q;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
            adjust_q    <= adjust_d;
            field_sel_q <= field_sel_d;
            up_q        <= up_d;
            down_q      <= down_d;
            blink_q     <= blink_d;
        end
    end

    assign adjust     = adjust_q;
    assign field_sel  = field_sel_q;
    assign up_pulse   = up_q;
    assign down_pulse = down_q;
    assign blink      = blink_q;

endmodule

// File: doc/clock_adjust_ctrl.md
# clock_adjust_ctrl

Set-mode controller for the millennium clock. Turns three raw push-buttons into a clean adjustment sequence for the time/date counter chain: it selects one field (second → minute → hour → day → month → year), drives the shared `adjust` level and emits single-cycle up/down pulses with auto-repeat. It leaves set mode after a mode-press past year or after an inactivity timeout. It sits between the button pads and the field counters, on the fast system clock.

## Interface

**Parameters**
- `DEB_CYCLES`, 16'd50000: consecutive stable samples needed to accept a button level change.
- `REPEAT_DELAY`, 24'd5000000: cycles a held up/down button must stay pressed before auto-repeat starts.
- `REPEAT_PERIOD`, 24'd1000000: cycles between auto-repeat pulses.
- `TIMEOUT_S`, 6'd30: `tick_1hz` pulses without any accepted press before returning to RUN.

**Ports**
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, asynchronous, active-high.
- `tick_1hz` in 1: one-`clk`-wide enable pulse, once per second.
- `btn_mode` in 1: raw mode button, asynchronous, active-high.
- `btn_up` in 1: raw up button, asynchronous, active-high.
- `btn_down` in 1: raw down button, asynchronous, active-high.
- `adjust` out 1: 1 in any SEL state, 0 in RUN.
- `field_sel` out 6: one-hot field select {year, month, day, hour, min, sec}; 0 in RUN.
- `up_pulse` out 1: single-cycle increment request for the selected field.
- `down_pulse` out 1: single-cycle decrement request for the selected field.
- `blink` out 1: display blink phase for the selected field; constant 1 in RUN.

## Operation

- **Input path.** Each button goes through a 2-flop synchronizer and then its own debouncer. The debounced level changes only after `DEB_CYCLES` consecutive synchronized samples differ from the current level. Any differing-then-matching glitch restarts the count.
- **Press event.** A press event is a one-cycle pulse on a debounced 0→1 transition. Releases generate no event.
- **FSM states:** RUN, SEL_SEC, SEL_MIN, SEL_HOUR, SEL_DAY, SEL_MONTH, SEL_YEAR.
  - A mode press in RUN goes to SEL_SEC.
  - A mode press in SEL_x goes to the next field.
  - A mode press in SEL_YEAR goes to RUN.
  - A timeout in any SEL state goes to RUN.
- **Outputs per state.** `field_sel` is one-hot matching the state (SEL_SEC = 6'b000001 … SEL_YEAR = 6'b100000). `adjust` = (state != RUN).
- **Up/down.** Active only in SEL states; ignored in RUN.
  - An up press event produces `up_pulse`; a down press event produces `down_pulse`.
  - If both debounced levels are high at the same time, no pulses are generated and the repeat counters are held at 0.
  - A mode press has priority: if a mode press and an up/down press occur in the same cycle, the state advances and no up/down pulse is issued.
- **Auto-repeat.** While exactly one of up/down stays debounced-high in a SEL state, a counter runs from its press event.
  - The first repeat pulse comes `REPEAT_DELAY` cycles after the press pulse.
  - Further pulses follow every `REPEAT_PERIOD` cycles.
  - Release, a state change or the both-pressed condition clears the counter.
- **Timeout.** A seconds counter clears on any accepted press event (mode, up or down) and on entry to a SEL state. It increments on each `tick_1hz` while in a SEL state. Reaching `TIMEOUT_S` forces RUN. The counter is held at 0 in RUN.
- **Blink.** Toggles on each `tick_1hz` in SEL states. It is set to 1 on entry to any SEL state, so the field is visible immediately after selection.
- **Width rules.**
  - Debounce counters are 16 bits, repeat counters 24 bits, the timeout counter 6 bits.
  - Counters saturate; they never wrap.
- **Reset mid-operation.** Reset forces RUN and clears all counters, synchronizers and debounced levels, even if a button is held. A button held through reset release is accepted as a new press only after `DEB_CYCLES` stable-high samples.

## Timing

- **Reset values:**
  - `adjust` = 0
  - `field_sel` = 6'b000000
  - `up_pulse` = 0
  - `down_pulse` = 0
  - `blink` = 1
  - state = RUN.
- **Press latency.** With a raw input stepping to 1 and held, sampled high first at edge k:
  - the debounced level rises at edge k+2+`DEB_CYCLES`;
  - the press event, state change and `up_pulse`/`down_pulse` are registered at the next edge, k+3+`DEB_CYCLES`.
- **Pulse width.** `up_pulse` and `down_pulse` are exactly one `clk` wide and never both high in the same cycle.
- **Timeout exit.** `adjust` falls on the edge after the `tick_1hz` cycle in which the counter reaches `TIMEOUT_S`.
- **Output registers.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- **Mode cycling.** `DEB_CYCLES`=4, `TIMEOUT_S`=3. Apply 7 clean mode presses. Required: `field_sel` goes 000001, 000010, 000100, 001000, 010000, 100000, then 000000 with `adjust` 0. Each change occurs exactly 7 cycles after the raw rise.
- **Bounce rejection.** Toggle `btn_up` high/low every 2 cycles for 20 cycles in SEL_SEC, then hold it high. Required: no pulse during bouncing; exactly one `up_pulse` 7 cycles after the final rise.
- **Auto-repeat.** `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5. Hold `btn_down` 50 cycles past the debounce. Required: press pulse, then repeats at +20, +25, +30, +35, +40, +45; none after release; no `up_pulse` at any point.
- **Simultaneous and RUN-mode presses.** Up and down pressed together in SEL_HOUR gives zero pulses. Up pressed in RUN gives zero pulses and `adjust` stays 0.
- **Timeout.** Enter SEL_MIN, then apply 3 `tick_1hz` with no presses. Required: RUN after the 3rd tick. A repeat run with an up press before the 3rd tick resets the count, so 3 more ticks are needed.
- **Reset mid-operation.** Assert `rst` asynchronously in SEL_YEAR while `btn_up` is held and auto-repeating. Required: outputs take their reset values immediately, with no pulse. After release, no `up_pulse` occurs because the FSM is in RUN.
